// File: rtl/saradc_pkg.sv
// Shared types and constants for the SAR ADC digital controller.
package saradc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SAMP = 2'd1,
        CONV = 2'd2,
        DONE = 2'd3
    } sar_state_t;

    localparam int NBITS_DEFAULT = 8;

    // Ceiling log2; returns 0 for values of 1 or less.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                r = i + 1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/saradc_out_reg.sv
// Valid/ready holding register for finished conversion codes.
// A code that arrives while an unconsumed one is held is dropped and flagged.
module saradc_out_reg #(
    parameter int NBITS = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load_i,
    input  logic [NBITS-1:0] data_i,
    input  logic             ready_i,
    output logic [NBITS-1:0] dout_o,
    output logic             valid_o,
    output logic             overrun_o
);

    logic [NBITS-1:0] dout_q, dout_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;

    // Next-state for the holding register and sticky overrun flag.
    always_comb begin
        dout_d  = dout_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (load_i) begin
            if (!valid_q || ready_i) begin
                dout_d  = data_i;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // State registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            dout_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            dout_q  <= dout_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign dout_o    = dout_q;
    assign valid_o   = valid_q;
    assign overrun_o = ovr_q;

endmodule

// File: rtl/saradc_sar_logic.sv
// SAR controller: sample/convert/done sequencing, MSB-first binary search
// driving the DAC switch codes, and a valid/ready result port.
module saradc_sar_logic
    import saradc_pkg::*;
#(
    parameter int NBITS   = NBITS_DEFAULT,
    parameter int NSAMPLE = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             CONT,
    input  logic             CMPO,
    output logic             SAMPLE,
    output logic [NBITS-1:0] RESULTP,
    output logic [NBITS-1:0] RESULTN,
    output logic             VALID,
    output logic [NBITS-1:0] DOUT,
    output logic             DOUT_VALID,
    input  logic             DOUT_READY,
    output logic             OVERRUN,
    output logic             BUSY
);

    localparam int PW = (clog2(NBITS) > 0) ? clog2(NBITS) : 1;

    sar_state_t       state_q, state_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [NBITS-1:0] resp_q, resp_d;
    logic [NBITS-1:0] resn_q, resn_d;
    logic             sample_q, sample_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             load_s;

    // Sequencing and SAR bit decisions; undecided bits stay 0 on both sides.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        resp_d  = resp_q;
        resn_d  = resn_q;
        load_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (START) begin
                    state_d = SAMP;
                    cnt_d   = 4'd0;
                    resp_d  = '0;
                    resn_d  = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            SAMP: begin
                if (cnt_q == 4'(NSAMPLE - 1)) begin
                    state_d = CONV;
                    ptr_d   = PW'(NBITS - 1);
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            CONV: begin
                resp_d[ptr_q] = CMPO;
                resn_d[ptr_q] = ~CMPO;
                if (ptr_q == PW'(0)) begin
                    state_d = DONE;
                    load_s  = 1'b1;
                end else begin
                    ptr_d = ptr_q - PW'(1);
                end
            end
            DONE: begin
                if (CONT) begin
                    state_d = SAMP;
                    cnt_d   = 4'd0;
                    resp_d  = '0;
                    resn_d  = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        sample_d = (state_d == SAMP);
        valid_d  = (state_d == DONE);
        busy_d   = (state_d != IDLE);
    end

    // Controller state and registered analog-side outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            cnt_q    <= 4'd0;
            resp_q   <= '0;
            resn_q   <= '0;
            sample_q <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            resp_q   <= resp_d;
            resn_q   <= resn_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
        end
    end

    // The full code (including bit 0 decided this edge) loads as DONE is entered.
    saradc_out_reg #(
        .NBITS (NBITS)
    ) u_out_reg (
        .CLK       (CLK),
        .RST       (RST),
        .load_i    (load_s),
        .data_i    (resp_d),
        .ready_i   (DOUT_READY),
        .dout_o    (DOUT),
        .valid_o   (DOUT_VALID),
        .overrun_o (OVERRUN)
    );

    assign SAMPLE  = sample_q;
    assign RESULTP = resp_q;
    assign RESULTN = resn_q;
    assign VALID   = valid_q;
    assign BUSY    = busy_q;

endmodule

// File: doc/saradc_sar_logic.md
Name: saradc_sar_logic

Overview:
- Synchronous SAR controller that sits directly upstream and downstream of the SAR ADC analog macro.
- Drives SAMPLE, RESULTP, RESULTN and VALID into the analog block.
- Consumes the comparator decision CMPO and runs a binary search, MSB first.
- Presents each finished code on a valid/ready output port to the rest of the digital system, with a sticky overrun flag.

Parameters:
- NBITS, 8, resolution of the converter; must match the analog block.
- NSAMPLE, 2, number of CLK cycles SAMPLE is held high (range 1..15).

Ports:
- CLK  input  1  conversion clock; the same net that feeds the analog block CLK.
- RST  input  1  reset, asynchronous, active-high.
- START  input  1  request one conversion; sampled only in IDLE.
- CONT  input  1  continuous mode; when 1, DONE goes straight to SAMPLE.
- CMPO  input  1  comparator decision from the analog block; 1 means VOUTH > VOUTL.
- SAMPLE  output  1  sample/hold control to the analog block.
- RESULTP  output  NBITS  positive-side DAC switch code.
- RESULTN  output  NBITS  negative-side DAC switch code.
- VALID  output  1  one-cycle end-of-conversion strobe to the analog block.
- DOUT  output  NBITS  captured conversion result.
- DOUT_VALID  output  1  DOUT holds an unconsumed result.
- DOUT_READY  input  1  consumer accepts DOUT when DOUT_VALID is high.
- OVERRUN  output  1  sticky: a result was dropped; cleared only by RST.
- BUSY  output  1  high in every state except IDLE.

Behaviour:
- Reset values: state IDLE; SAMPLE=0, RESULTP=0, RESULTN=0, VALID=0, DOUT=0, DOUT_VALID=0, OVERRUN=0, BUSY=0. The internal bit pointer and sample counter are also 0.
- Reset is asynchronous, including mid-conversion: all outputs return to their reset values immediately, and any partial code is discarded.
- All outputs are registered. CMPO is sampled on the rising edge of CLK.
- States: IDLE, SAMP, CONV, DONE.
- IDLE:
  - START=1 at an edge -> SAMP.
  - START is ignored in every other state.
- SAMP:
  - SAMPLE=1 for exactly NSAMPLE cycles.
  - RESULTP and RESULTN are cleared to 0 on entry.
  - After NSAMPLE cycles -> CONV, with pointer b=NBITS-1.
- CONV, one decision per edge:
  - At each edge, D[b] is set to CMPO.
  - On the same edge, RESULTP[b]=D[b] and RESULTN[b]=~D[b]. Bits not yet decided stay 0 in both vectors (monotonic switching).
  - b then decrements.
  - After the edge that decides bit 0 -> DONE. CONV therefore lasts exactly NBITS cycles.
- DONE, one cycle:
  - VALID=1.
  - RESULTP/RESULTN hold the final code.
  - Next state: SAMP if CONT=1, else IDLE.
- Latency: from the edge that samples START to the edge that sets DOUT_VALID is NSAMPLE+NBITS edges.
  - DOUT/DOUT_VALID update on the same edge that enters DONE, so they are visible in the same cycle as VALID.
- Output handshake:
  - A transfer occurs on an edge where DOUT_VALID=1 and DOUT_READY=1.
  - After a transfer, DOUT_VALID clears unless a new result is loaded on that same edge.
  - New result arrives while DOUT_VALID=1 and DOUT_READY=0: DOUT keeps the old value, the new code is dropped, and OVERRUN is set.
  - New result arrives on the same edge as a transfer: the new code loads, DOUT_VALID stays 1, and OVERRUN is not set.
  - DOUT is stable while DOUT_VALID=1 and no transfer has occurred.
- CONT deasserted mid-conversion: the current conversion completes, then the block returns to IDLE.
- Width rules: the pointer is clog2(NBITS) bits wide; the sample counter is 4 bits.

Decomposition:
- Shared package saradc_pkg holds:
  - state enum sar_state_t (IDLE, SAMP, CONV, DONE);
  - localparam NBITS_DEFAULT=8;
  - the function clog2.
- One sub-module, saradc_out_reg: the valid/ready holding register with overrun detection. The FSM and the SAR register stay in the top module.

Test Plan:
- Reset then idle: RST pulse, START=0 for 20 cycles -> all outputs 0, BUSY=0, no VALID.
- Single conversion (NBITS=8, NSAMPLE=2): START=1 for one edge, then drive CMPO = 1,0,1,0,0,1,0,1 on the CONV edges.
  - SAMPLE is high for 2 cycles.
  - RESULTP builds 0x80, 0x80, 0xA0, 0xA0, 0xA0, 0xA4, 0xA4, 0xA5.
  - DOUT=0xA5 with DOUT_VALID=1 and VALID=1 exactly 10 edges after the START edge; RESULTN=0x5A at DONE.
- Continuous mode with DOUT_READY=1 and CMPO alternating codes 0xFF and 0x00:
  - back-to-back conversions every NSAMPLE+NBITS+1 = 11 cycles;
  - DOUT alternates 0xFF/0x00 and OVERRUN stays 0.
- Overrun: CONT=1, DOUT_READY=0 -> DOUT holds the first code, OVERRUN=1 after the second DONE. Raising DOUT_READY for one edge clears DOUT_VALID; OVERRUN stays 1.
- Simultaneous transfer and load: DOUT_READY=1 asserted exactly on the DONE edge of the second result -> DOUT updates, DOUT_VALID stays 1, OVERRUN=0.
- Reset mid-operation: RST asserted during CONV after 3 decisions -> RESULTP/RESULTN=0 and state IDLE immediately, with no VALID pulse. A subsequent START converts normally.
